// File: rtl/dtmf_pkg.sv
// Shared key codes, validator FSM states and the one-hot tone decoder.
package dtmf_pkg;

  localparam logic [3:0] KEY_0    = 4'd0;
  localparam logic [3:0] KEY_1    = 4'd1;
  localparam logic [3:0] KEY_2    = 4'd2;
  localparam logic [3:0] KEY_3    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_7    = 4'd7;
  localparam logic [3:0] KEY_8    = 4'd8;
  localparam logic [3:0] KEY_9    = 4'd9;
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAND = 2'd1,
    HELD = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Returns {valid, code}: valid only when exactly one tone bit is set.
  function automatic logic [4:0] onehot_to_code(input logic [15:0] tone);
    logic [3:0] code;
    logic [4:0] ones;
    code = 4'd0;
    ones = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (tone[i]) begin
        ones = ones + 5'd1;
        code = 4'(i);
      end
    end
    return {(ones == 5'd1), code};
  endfunction

endpackage

// File: rtl/dtmf_key_fifo.sv
// Show-ahead key FIFO: head presents the oldest entry (0 when empty).
module dtmf_key_fifo
  import dtmf_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [3:0]               push_data,
  input  logic                     pop,
  output logic [3:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = empty ? 4'd0 : mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/dtmf_key_validator.sv
// Debounces per-frame tone decisions into key-press events queued in a FIFO.
module dtmf_key_validator
  import dtmf_pkg::*;
#(
  parameter int ON_FRAMES      = 3,
  parameter int OFF_FRAMES     = 2,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          det_done,
  input  logic                          det_error,
  input  logic [15:0]                   det_tone,
  output logic                          key_valid,
  output logic [3:0]                    key_code,
  input  logic                          key_ready,
  output logic                          key_active,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  state_t        state_reg, state_next;
  logic [3:0]    cand_reg, cand_next;
  logic [3:0]    on_cnt_reg, on_cnt_next;
  logic [3:0]    off_cnt_reg, off_cnt_next;
  logic [TW-1:0] tmo_reg;
  logic          overflow_reg;

  logic [4:0]    decode;
  logic          timeout_hit;
  logic          frame_evt;
  logic          frame_ok;
  logic [3:0]    frame_key;
  logic          match;
  logic          push_key;
  logic          fifo_full;
  logic          fifo_empty;

  // An expiry coinciding with det_done is swallowed by the real frame.
  assign timeout_hit = !det_done && (tmo_reg == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      tmo_reg <= '0;
    end else if (det_done || timeout_hit) begin
      tmo_reg <= '0;
    end else begin
      tmo_reg <= tmo_reg + 1'b1;
    end
  end

  assign decode    = onehot_to_code(det_tone);
  assign frame_evt = det_done || timeout_hit;
  assign frame_ok  = det_done && !det_error && decode[4];
  assign frame_key = decode[3:0];
  assign match     = frame_ok && (frame_key == cand_reg);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= IDLE;
      cand_reg    <= 4'd0;
      on_cnt_reg  <= 4'd0;
      off_cnt_reg <= 4'd0;
    end else begin
      state_reg   <= state_next;
      cand_reg    <= cand_next;
      on_cnt_reg  <= on_cnt_next;
      off_cnt_reg <= off_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cand_next    = cand_reg;
    on_cnt_next  = on_cnt_reg;
    off_cnt_next = off_cnt_reg;
    push_key     = 1'b0;
    if (frame_evt) begin
      case (state_reg)
        IDLE: begin
          if (frame_ok) begin
            cand_next   = frame_key;
            on_cnt_next = 4'd1;
            if (ON_FRAMES == 1) begin
              push_key   = 1'b1;
              state_next = HELD;
            end else begin
              state_next = CAND;
            end
          end
        end
        CAND: begin
          if (match) begin
            if (({1'b0, on_cnt_reg} + 5'd1) == 5'(ON_FRAMES)) begin
              push_key   = 1'b1;
              state_next = HELD;
            end else if (on_cnt_reg != 4'hF) begin
              on_cnt_next = on_cnt_reg + 4'd1;
            end
          end else if (frame_ok) begin
            cand_next   = frame_key;
            on_cnt_next = 4'd1;
          end else begin
            on_cnt_next = 4'd0;
            state_next  = IDLE;
          end
        end
        HELD: begin
          if (!match) begin
            if (OFF_FRAMES == 1) begin
              off_cnt_next = 4'd0;
              state_next   = IDLE;
            end else begin
              off_cnt_next = 4'd1;
              state_next   = GAP;
            end
          end
        end
        GAP: begin
          // A dropout followed by the same key is one continuous press.
          if (match) begin
            off_cnt_next = 4'd0;
            state_next   = HELD;
          end else if (({1'b0, off_cnt_reg} + 5'd1) == 5'(OFF_FRAMES)) begin
            off_cnt_next = 4'd0;
            state_next   = IDLE;
          end else if (off_cnt_reg != 4'hF) begin
            off_cnt_next = off_cnt_reg + 4'd1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  dtmf_key_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_key),
    .push_data (frame_key),
    .pop       (key_ready),
    .head      (key_code),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Set wins over clear when both happen in one cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      overflow_reg <= 1'b0;
    end else if (push_key && fifo_full && !key_ready) begin
      overflow_reg <= 1'b1;
    end else if (ovf_clr) begin
      overflow_reg <= 1'b0;
    end
  end

  assign key_valid  = !fifo_empty;
  assign key_active = (state_reg == HELD) || (state_reg == GAP);
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_dtmf_key_validator.sv
// Directed bench for dtmf_key_validator with default parameters.
module tb_dtmf_key_validator;
  import dtmf_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        det_done = 1'b0;
  logic        det_error = 1'b0;
  logic [15:0] det_tone = 16'h0000;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready = 1'b0;
  logic        key_active;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        ovf_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dtmf_key_validator dut (
    .clock      (clock),
    .reset      (reset),
    .det_done   (det_done),
    .det_error  (det_error),
    .det_tone   (det_tone),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .key_active (key_active),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // One det_done pulse; returns at the falling edge after it was sampled.
  task automatic frame(input logic [15:0] tone, input logic err);
    @(negedge clock);
    det_done  = 1'b1;
    det_tone  = tone;
    det_error = err;
    @(negedge clock);
    det_done  = 1'b0;
    det_tone  = 16'h0000;
    det_error = 1'b0;
  endtask

  task automatic key_frame(input logic [3:0] k);
    logic [15:0] t;
    t = 16'h0001 << k;
    frame(t, 1'b0);
  endtask

  task automatic press(input logic [3:0] k);
    repeat (3) key_frame(k);
    repeat (2) frame(16'h0000, 1'b0);
  endtask

  task automatic pop_one();
    @(negedge clock);
    key_ready = 1'b1;
    @(negedge clock);
    key_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst key_valid", key_valid, 0);
    check("rst key_code", key_code, 0);
    check("rst key_active", key_active, 0);
    check("rst fifo_count", fifo_count, 0);
    check("rst overflow", overflow, 0);
    reset = 1'b1;

    // key 5 accepted after the third matching frame, survives a one-frame dropout
    key_frame(KEY_5);
    key_frame(KEY_5);
    check("k5 two frames no key", key_valid, 0);
    key_frame(KEY_5);
    check("k5 key_valid", key_valid, 1);
    check("k5 key_code", key_code, 5);
    check("k5 key_active", key_active, 1);
    check("k5 fifo_count", fifo_count, 1);
    frame(16'h0000, 1'b0);
    check("k5 gap active", key_active, 1);
    key_frame(KEY_5);
    key_frame(KEY_5);
    frame(16'h0000, 1'b0);
    check("k5 1st release active", key_active, 1);
    frame(16'h0000, 1'b0);
    check("k5 2nd release inactive", key_active, 0);
    check("k5 single entry", fifo_count, 1);
    pop_one();
    check("k5 popped", fifo_count, 0);

    // candidate switch: 5,5,7,7,7 yields only key 7
    key_frame(KEY_5);
    key_frame(KEY_5);
    key_frame(KEY_7);
    key_frame(KEY_7);
    check("switch not yet", fifo_count, 0);
    key_frame(KEY_7);
    check("switch count", fifo_count, 1);
    check("switch code", key_code, 7);
    repeat (2) frame(16'h0000, 1'b0);
    pop_one();

    // invalid frames never leave IDLE
    repeat (3) frame(16'h0021, 1'b0);
    repeat (3) frame(16'h0000, 1'b0);
    repeat (3) frame(16'h0001, 1'b1);
    check("invalid count", fifo_count, 0);
    check("invalid active", key_active, 0);

    // fill to overflow with keys 0..8
    for (int i = 0; i < 8; i++) press(4'(i));
    check("fill count", fifo_count, 8);
    check("fill no overflow", overflow, 0);
    press(4'd8);
    check("ovf count", fifo_count, 8);
    check("ovf flag", overflow, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain code %0d", i), key_code, i);
      pop_one();
    end
    check("drain empty", fifo_count, 0);
    check("drain key_valid", key_valid, 0);
    pop_one();
    check("pop empty ignored", fifo_count, 0);
    check("ovf sticky", overflow, 1);
    @(negedge clock);
    ovf_clr = 1'b1;
    @(negedge clock);
    ovf_clr = 1'b0;
    check("ovf cleared", overflow, 0);

    // hold key 15 then let the detector go silent
    repeat (3) key_frame(KEY_HASH);
    check("hash code", key_code, 15);
    check("hash active", key_active, 1);
    repeat (4096) @(negedge clock);
    check("timeout1 still active", key_active, 1);
    repeat (4095) @(negedge clock);
    check("timeout pre-release", key_active, 1);
    @(negedge clock);
    check("timeout released", key_active, 0);

    // reset mid-candidate clears everything
    key_frame(KEY_1);
    key_frame(KEY_1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("mid rst key_valid", key_valid, 0);
    check("mid rst key_code", key_code, 0);
    check("mid rst fifo_count", fifo_count, 0);
    check("mid rst active", key_active, 0);
    reset = 1'b1;
    key_frame(KEY_1);
    key_frame(KEY_1);
    check("cand discarded", fifo_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
